alu_status_stage: RTL and testbench

- Registered stage directly downstream of the ALU flag calculator.
- Accepts each ALU result together with its N/V/Z/Cout flags through a valid/ready handshake, and buffers up to 2 beats in a skid buffer.
- Commits flags to an architectural NZCV status register as beats leave the stage, maintains a sticky overflow bit, and evaluates a 4-bit condition code against the committed status for the downstream sequencer.

---
 rtl/alu_status_stage.sv | 165 ++++++++++++++++
 tb/tb_alu_status_stage.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_status_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_status_stage
// Brief    : Two-entry skid stage after the ALU flag calculator; commits NZCV
//            status and sticky overflow on retire and evaluates condition codes.
// Revision : 1.0 - initial release
// ============================================================================
module alu_status_stage #(
    parameter int W   = 4,
    parameter int OPW = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [OPW-1:0] in_opcode,
    input  logic [W-1:0]   in_result,
    input  logic           in_negative,
    input  logic           in_overflow,
    input  logic           in_zero,
    input  logic           in_cout,
    input  logic           in_upd,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [OPW-1:0] out_opcode,
    output logic [W-1:0]   out_result,
    output logic [3:0]     out_flags,
    output logic [3:0]     status,
    output logic           sticky_v,
    input  logic           sticky_clr,
    input  logic [3:0]     cond,
    output logic           cond_true
);

    localparam logic [1:0] c_empty = 2'd0;
    localparam logic [1:0] c_one   = 2'd1;
    localparam logic [1:0] c_full  = 2'd2;

    // Entry layout: {opcode, result, N, Z, C, V, upd}
    localparam int c_ew = OPW + W + 5;

    logic [1:0]      r_state;
    logic [1:0]      w_next_state;
    logic            r_in_ready;
    logic [c_ew-1:0] r_head;
    logic [c_ew-1:0] r_tail;
    logic [c_ew-1:0] w_in_entry;
    logic [3:0]      r_status;
    logic            r_sticky_v;
    logic            w_accept;
    logic            w_retire;
    logic            w_n;
    logic            w_z;
    logic            w_c;
    logic            w_v;

    assign w_in_entry = {in_opcode, in_result, in_negative, in_zero,
                         in_cout, in_overflow, in_upd};
    assign w_accept   = in_valid && r_in_ready;
    assign w_retire   = out_valid && out_ready;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_empty;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_next_state;
            r_in_ready <= (w_next_state != c_full);
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_empty: if (w_accept) w_next_state = c_one;
            c_one: begin
                if (w_accept && !w_retire)      w_next_state = c_full;
                else if (!w_accept && w_retire) w_next_state = c_empty;
            end
            c_full:  if (w_retire) w_next_state = c_one;
            default: w_next_state = c_empty;
        endcase
    end

    // Output logic
    always_comb begin
        out_valid = (r_state != c_empty);
    end

    assign in_ready = r_in_ready;

    // Simultaneous accept/retire in ONE replaces the head directly so the
    // tail slot is only ever used while the head is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            if ((r_state == c_empty && w_accept) ||
                (r_state == c_one && w_accept && w_retire)) begin
                r_head <= w_in_entry;
            end else if (r_state == c_full && w_retire) begin
                r_head <= r_tail;
            end
            if (r_state == c_one && w_accept && !w_retire) begin
                r_tail <= w_in_entry;
            end
        end
    end

    assign out_opcode = r_head[c_ew-1 -: OPW];
    assign out_result = r_head[W+4:5];
    assign out_flags  = r_head[4:1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_status   <= 4'b0000;
            r_sticky_v <= 1'b0;
        end else begin
            if (w_retire && r_head[0]) begin
                r_status <= r_head[4:1];
            end
            if (w_retire && r_head[0] && r_head[1]) begin
                r_sticky_v <= 1'b1;
            end else if (sticky_clr) begin
                r_sticky_v <= 1'b0;
            end
        end
    end

    assign status   = r_status;
    assign sticky_v = r_sticky_v;

    assign w_n = r_status[3];
    assign w_z = r_status[2];
    assign w_c = r_status[1];
    assign w_v = r_status[0];

    // Evaluated against committed status only, never the head flags
    always_comb begin
        cond_true = 1'b0;
        case (cond)
            4'd0:  cond_true = w_z;
            4'd1:  cond_true = !w_z;
            4'd2:  cond_true = w_c;
            4'd3:  cond_true = !w_c;
            4'd4:  cond_true = w_n;
            4'd5:  cond_true = !w_n;
            4'd6:  cond_true = w_v;
            4'd7:  cond_true = !w_v;
            4'd8:  cond_true = w_c && !w_z;
            4'd9:  cond_true = !w_c || w_z;
            4'd10: cond_true = (w_n == w_v);
            4'd11: cond_true = (w_n != w_v);
            4'd12: cond_true = !w_z && (w_n == w_v);
            4'd13: cond_true = w_z || (w_n != w_v);
            4'd14: cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_status_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_status_stage
// Brief    : Directed self-checking bench for alu_status_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_status_stage;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_opcode;
    logic [3:0] in_result;
    logic       in_negative;
    logic       in_overflow;
    logic       in_zero;
    logic       in_cout;
    logic       in_upd;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_opcode;
    logic [3:0] out_result;
    logic [3:0] out_flags;
    logic [3:0] status;
    logic       sticky_v;
    logic       sticky_clr;
    logic [3:0] cond;
    logic       cond_true;

    int n_total;
    int n_bad;

    alu_status_stage #(.W(4), .OPW(4)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_opcode   (in_opcode),
        .in_result   (in_result),
        .in_negative (in_negative),
        .in_overflow (in_overflow),
        .in_zero     (in_zero),
        .in_cout     (in_cout),
        .in_upd      (in_upd),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_opcode  (out_opcode),
        .out_result  (out_result),
        .out_flags   (out_flags),
        .status      (status),
        .sticky_v    (sticky_v),
        .sticky_clr  (sticky_clr),
        .cond        (cond),
        .cond_true   (cond_true)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Present one beat; flags given as {N,Z,C,V}
    task automatic drive(input logic v, input logic [3:0] res, input logic [3:0] nzcv, input logic upd);
        in_valid    = v;
        in_opcode   = res ^ 4'hA;
        in_result   = res;
        in_negative = nzcv[3];
        in_zero     = nzcv[2];
        in_cout     = nzcv[1];
        in_overflow = nzcv[0];
        in_upd      = upd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_total    = 0;
        n_bad      = 0;
        rst        = 1'b1;
        out_ready  = 1'b0;
        sticky_clr = 1'b0;
        cond       = 4'd1;
        drive(1'b0, 4'h0, 4'b0000, 1'b0);

        // Reset state
        step();
        step();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_status", status, 0);
        check("rst_sticky", sticky_v, 0);
        check("rst_out_result", out_result, 0);
        check("rst_cond_ne", cond_true, 1);
        cond = 4'd15;
        #1 check("rst_cond_nv", cond_true, 0);
        cond = 4'd0;
        #1 check("rst_cond_eq", cond_true, 0);
        step();
        rst = 1'b0;

        // Single beat, Z=1
        out_ready = 1'b1;
        drive(1'b1, 4'h0, 4'b0100, 1'b1);
        step();
        drive(1'b0, 4'h0, 4'b0000, 1'b0);
        check("single_out_valid", out_valid, 1);
        check("single_out_result", out_result, 0);
        check("single_out_flags", out_flags, 4'b0100);
        check("single_out_opcode", out_opcode, 4'hA);
        check("single_status_pre", status, 0);
        check("single_cond_pre", cond_true, 0);
        step();
        check("single_status", status, 4'b0100);
        check("single_cond_eq", cond_true, 1);
        check("single_empty", out_valid, 0);

        // Backpressure: three beats, second fills the buffer
        out_ready = 1'b0;
        drive(1'b1, 4'h1, 4'b0000, 1'b0);
        step();
        check("bp_ready1", in_ready, 1);
        drive(1'b1, 4'h2, 4'b0000, 1'b0);
        step();
        check("bp_ready2", in_ready, 0);
        check("bp_head1", out_result, 1);
        drive(1'b1, 4'h3, 4'b0000, 1'b0);
        step();
        check("bp_held_ready", in_ready, 0);
        check("bp_head_stable", out_result, 1);
        check("bp_valid", out_valid, 1);
        out_ready = 1'b1;
        step();
        check("bp_ret2", out_result, 2);
        check("bp_ready_back", in_ready, 1);
        step();
        drive(1'b0, 4'h0, 4'b0000, 1'b0);
        check("bp_ret3", out_result, 3);
        check("bp_ret3_valid", out_valid, 1);
        step();
        check("bp_drained", out_valid, 0);
        check("bp_status_kept", status, 4'b0100);

        // Streaming 0..7 with out_ready held high
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 4'(i), 4'b0000, 1'b0);
            step();
            check("stream_valid", out_valid, 1);
            check("stream_result", out_result, i);
            check("stream_ready", in_ready, 1);
        end
        drive(1'b0, 4'h0, 4'b0000, 1'b0);
        step();
        check("stream_drained", out_valid, 0);

        // Overflow beat sets status V and sticky
        drive(1'b1, 4'h5, 4'b0001, 1'b1);
        step();
        drive(1'b0, 4'h0, 4'b0000, 1'b0);
        check("v_sticky_pre", sticky_v, 0);
        step();
        check("v_status", status, 4'b0001);
        check("v_sticky", sticky_v, 1);
        cond = 4'd11;
        #1 check("v_cond_lt", cond_true, 1);
        cond = 4'd10;
        #1 check("v_cond_ge", cond_true, 0);

        // upd=0 beat leaves status alone
        drive(1'b1, 4'h6, 4'b1111, 1'b0);
        step();
        drive(1'b0, 4'h0, 4'b0000, 1'b0);
        check("noupd_flags", out_flags, 4'b1111);
        check("noupd_cond_head_ignored", cond_true, 0);
        step();
        check("noupd_status", status, 4'b0001);

        // Set wins over simultaneous clear
        drive(1'b1, 4'h7, 4'b1001, 1'b1);
        step();
        drive(1'b0, 4'h0, 4'b0000, 1'b0);
        sticky_clr = 1'b1;
        step();
        sticky_clr = 1'b0;
        check("setclr_sticky", sticky_v, 1);
        check("setclr_status", status, 4'b1001);
        cond = 4'd12;
        #1 check("setclr_cond_gt", cond_true, 1);
        sticky_clr = 1'b1;
        step();
        sticky_clr = 1'b0;
        check("clr_sticky", sticky_v, 0);

        // Build status=1010, then fill the buffer
        drive(1'b1, 4'h8, 4'b1010, 1'b1);
        step();
        drive(1'b0, 4'h0, 4'b0000, 1'b0);
        step();
        check("pre_rst_status", status, 4'b1010);
        cond = 4'd8;
        #1 check("pre_rst_cond_hi", cond_true, 1);
        out_ready = 1'b0;
        drive(1'b1, 4'h9, 4'b0000, 1'b0);
        step();
        drive(1'b1, 4'hA, 4'b0000, 1'b0);
        step();
        drive(1'b0, 4'h0, 4'b0000, 1'b0);
        check("pre_rst_full", in_ready, 0);

        // Asynchronous reset between edges
        #2 rst = 1'b1;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_in_ready", in_ready, 1);
        check("arst_status", status, 0);
        check("arst_out_result", out_result, 0);
        check("arst_cond_hi", cond_true, 0);
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, 4'hC, 4'b0000, 1'b0);
        step();
        drive(1'b0, 4'h0, 4'b0000, 1'b0);
        check("post_rst_valid", out_valid, 1);
        check("post_rst_result", out_result, 4'hC);
        step();
        check("post_rst_empty", out_valid, 0);
        step();
        check("post_rst_still_empty", out_valid, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
